// File: rtl/oven_controller_if.sv
// Bundle between front panel / temperature model (master) and the oven sequencer (slave).
interface oven_controller_if;
    logic        start;
    logic        cancel;
    logic [9:0]  targetIn;
    logic [11:0] cookTimeIn;
    logic [9:0]  currentTemp;
    logic        preheated;
    logic        heat;
    logic        tempInputDone;
    logic [2:0]  state;
    logic [11:0] timeLeft;
    logic        done;
    logic        error;

    modport master (
        output start, cancel, targetIn, cookTimeIn, currentTemp, preheated,
        input  heat, tempInputDone, state, timeLeft, done, error
    );

    modport slave (
        input  start, cancel, targetIn, cookTimeIn, currentTemp, preheated,
        output heat, tempInputDone, state, timeLeft, done, error
    );
endinterface

// File: rtl/oven_controller.sv
// Oven sequencer: validates a cook request, preheats with bang-bang control,
// then regulates with hysteresis while counting the cook time down in seconds.
module oven_controller #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int HYST          = 2,
    parameter int MIN_TARGET    = 150,
    parameter int MAX_TARGET    = 500,
    parameter int OVER_MARGIN   = 20,
    parameter int PREHEAT_LIMIT = 900
) (
    input  logic              clk,
    input  logic              rst,
    oven_controller_if.slave  bus
);
    localparam int              PW        = $clog2(TICKS_PER_SEC + 1);
    localparam int              SW        = $clog2(PREHEAT_LIMIT + 1);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0]   SEC_LIMIT = SW'(PREHEAT_LIMIT);
    localparam logic [10:0]     HYST11    = 11'(HYST);
    localparam logic [10:0]     OVER11    = 11'(OVER_MARGIN);
    localparam logic [9:0]      MIN10     = 10'(MIN_TARGET);
    localparam logic [9:0]      MAX10     = 10'(MAX_TARGET);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREHEAT = 3'd1,
        S_COOK    = 3'd2,
        S_DONE    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_heat, w_heat_nxt;
    logic          r_tid, w_tid_nxt;
    logic          r_done, w_done_nxt;
    logic          r_error, w_error_nxt;
    logic          r_block, w_block_nxt;
    logic [11:0]   r_time_left, w_time_left_nxt;
    logic [11:0]   r_cook_time, w_cook_time_nxt;
    logic [9:0]    r_target, w_target_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt, w_presc_inc;
    logic [SW-1:0] r_sec, w_sec_nxt;
    logic [10:0]   w_tgt11, w_temp11;
    logic          w_wrap, w_over, w_below, w_below_hyst, w_valid, w_start_below;

    assign w_tgt11       = {1'b0, r_target};
    assign w_temp11      = {1'b0, bus.currentTemp};
    assign w_wrap        = (r_presc == PRESC_MAX);
    assign w_presc_inc   = w_wrap ? '0 : r_presc + PW'(1);
    assign w_over        = (w_temp11 > (w_tgt11 + OVER11));
    assign w_below       = (w_temp11 < w_tgt11);
    assign w_below_hyst  = (w_temp11 < (w_tgt11 - HYST11));
    assign w_start_below = (bus.currentTemp < bus.targetIn);
    assign w_valid       = (bus.targetIn >= MIN10) && (bus.targetIn <= MAX10) &&
                           (bus.cookTimeIn != 12'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_heat      <= 1'b0;
            r_tid       <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_block     <= 1'b0;
            r_time_left <= '0;
            r_cook_time <= '0;
            r_target    <= '0;
            r_presc     <= '0;
            r_sec       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_heat      <= w_heat_nxt;
            r_tid       <= w_tid_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_block     <= w_block_nxt;
            r_time_left <= w_time_left_nxt;
            r_cook_time <= w_cook_time_nxt;
            r_target    <= w_target_nxt;
            r_presc     <= w_presc_nxt;
            r_sec       <= w_sec_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_heat_nxt      = r_heat;
        w_tid_nxt       = r_tid;
        w_done_nxt      = 1'b0;
        w_error_nxt     = 1'b0;
        w_block_nxt     = r_block;
        w_time_left_nxt = r_time_left;
        w_cook_time_nxt = r_cook_time;
        w_target_nxt    = r_target;
        w_presc_nxt     = r_presc;
        w_sec_nxt       = r_sec;

        if (bus.cancel) begin
            w_state_nxt     = S_IDLE;
            w_heat_nxt      = 1'b0;
            w_time_left_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_heat_nxt = 1'b0;
                    // A start still held from the DONE acknowledge is ignored until it drops.
                    if (!bus.start) begin
                        w_block_nxt = 1'b0;
                    end else if (!r_block) begin
                        if (w_valid) begin
                            w_state_nxt     = S_PREHEAT;
                            w_target_nxt    = bus.targetIn;
                            w_cook_time_nxt = bus.cookTimeIn;
                            w_tid_nxt       = 1'b1;
                            w_presc_nxt     = '0;
                            w_sec_nxt       = '0;
                            w_heat_nxt      = w_start_below;
                        end else begin
                            w_error_nxt = 1'b1;
                        end
                    end
                end
                S_PREHEAT: begin
                    w_presc_nxt = w_presc_inc;
                    if (w_wrap) w_sec_nxt = r_sec + SW'(1);
                    if (w_over || (w_wrap && ((r_sec + SW'(1)) == SEC_LIMIT))) begin
                        w_state_nxt = S_FAULT;
                        w_heat_nxt  = 1'b0;
                        w_error_nxt = 1'b1;
                    end else if (bus.preheated) begin
                        w_state_nxt     = S_COOK;
                        w_time_left_nxt = r_cook_time;
                        w_presc_nxt     = '0;
                        w_heat_nxt      = w_below;
                    end else begin
                        w_heat_nxt = w_below;
                    end
                end
                S_COOK: begin
                    w_presc_nxt = w_presc_inc;
                    if (w_over) begin
                        w_state_nxt = S_FAULT;
                        w_heat_nxt  = 1'b0;
                        w_error_nxt = 1'b1;
                    end else if (w_wrap && (r_time_left == 12'd1)) begin
                        w_state_nxt     = S_DONE;
                        w_heat_nxt      = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_time_left_nxt = '0;
                    end else begin
                        if (w_wrap) w_time_left_nxt = r_time_left - 12'd1;
                        if (w_below_hyst) w_heat_nxt = 1'b1;
                        else if (!w_below) w_heat_nxt = 1'b0;
                    end
                end
                S_DONE: begin
                    w_heat_nxt      = 1'b0;
                    w_time_left_nxt = '0;
                    if (bus.start) begin
                        w_state_nxt = S_IDLE;
                        w_block_nxt = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
                S_FAULT: begin
                    w_heat_nxt  = 1'b0;
                    w_error_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_heat_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bus.state         = r_state;
    assign bus.heat          = r_heat;
    assign bus.tempInputDone = r_tid;
    assign bus.timeLeft      = r_time_left;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
endmodule

// File: tb/tb_oven_controller.sv
// Bench for oven_controller: directed vector table, hand sequences for reset,
// then randomized traffic against an elapsed-time reference model.
module tb_oven_controller;
    localparam int T   = 4;
    localparam int LIM = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    oven_controller_if bus();

    oven_controller #(
        .TICKS_PER_SEC(T), .HYST(2), .MIN_TARGET(150), .MAX_TARGET(500),
        .OVER_MARGIN(20), .PREHEAT_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start; logic cancel; int tgt; int ct; int temp; logic pre;
        int st; logic heat; logic tid; int tl; logic done; logic err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: phase plus cycles elapsed in that phase.
    int   m_state, m_tgt, m_ct, m_el, m_tl;
    logic m_heat, m_tid, m_done, m_err, m_block;

    function automatic void add(logic s, logic c, int tg, int ct, int tp, logic p,
                                int es, logic eh, logic et, int etl, logic ed, logic ee);
        vec_t v;
        v.start = s; v.cancel = c; v.tgt = tg; v.ct = ct; v.temp = tp; v.pre = p;
        v.st = es; v.heat = eh; v.tid = et; v.tl = etl; v.done = ed; v.err = ee;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, int st, logic heat, logic tid, int tl, logic done, logic err);
        n_total++;
        if (bus.state === 3'(st) && bus.heat === heat && bus.tempInputDone === tid &&
            bus.timeLeft === 12'(tl) && bus.done === done && bus.error === err) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got st=%0d heat=%b tid=%b tl=%0d done=%b err=%b, expected st=%0d heat=%b tid=%b tl=%0d done=%b err=%b",
                     nm, $time, bus.state, bus.heat, bus.tempInputDone, bus.timeLeft, bus.done, bus.error,
                     st, heat, tid, tl, done, err);
        end
    endtask

    task automatic drive(logic s, logic c, int tg, int ct, int tp, logic p);
        @(negedge clk);
        bus.start = s; bus.cancel = c;
        bus.targetIn = 10'(tg); bus.cookTimeIn = 12'(ct);
        bus.currentTemp = 10'(tp); bus.preheated = p;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0; m_tgt = 0; m_ct = 0; m_el = 0; m_tl = 0;
        m_heat = 0; m_tid = 0; m_done = 0; m_err = 0; m_block = 0;
    endtask

    task automatic model_step();
        int tp, ti, ci;
        tp = int'(bus.currentTemp);
        ti = int'(bus.targetIn);
        ci = int'(bus.cookTimeIn);
        m_err = 0;
        if (bus.cancel) begin
            m_state = 0; m_heat = 0; m_done = 0; m_tl = 0;
        end else if (m_state == 0) begin
            m_heat = 0;
            if (!bus.start) m_block = 0;
            else if (!m_block) begin
                if (ti >= 150 && ti <= 500 && ci != 0) begin
                    m_state = 1; m_tid = 1; m_tgt = ti; m_ct = ci; m_el = 0;
                    m_heat = (tp < ti);
                end else m_err = 1;
            end
        end else if (m_state == 1) begin
            m_el++;
            if (tp > m_tgt + 20 || m_el == LIM * T) begin
                m_state = 4; m_heat = 0; m_err = 1;
            end else begin
                m_heat = (tp < m_tgt);
                if (bus.preheated) begin
                    m_state = 2; m_el = 0; m_tl = m_ct;
                end
            end
        end else if (m_state == 2) begin
            m_el++;
            if (tp > m_tgt + 20) begin
                m_state = 4; m_heat = 0; m_err = 1;
            end else if (m_el == m_ct * T) begin
                m_state = 3; m_heat = 0; m_done = 1; m_tl = 0;
            end else begin
                m_tl = m_ct - m_el / T;
                if (tp < m_tgt - 2) m_heat = 1;
                else if (tp >= m_tgt) m_heat = 0;
            end
        end else if (m_state == 3) begin
            if (bus.start) begin
                m_state = 0; m_done = 0; m_block = 1;
            end
        end else begin
            m_err = 1;
        end
    endtask

    initial begin
        int base;
        bus.start = 0; bus.cancel = 0; bus.targetIn = 0; bus.cookTimeIn = 0;
        bus.currentTemp = 0; bus.preheated = 0;

        #1 rst = 1'b1;
        #2 chk("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;

        // start, preheat, full cook with hysteresis sweep
        add(1,0,350,3, 70,0, 1,1,1,0,0,0);
        add(0,0,350,3, 70,0, 1,1,1,0,0,0);
        add(0,0,350,3,350,1, 2,0,1,3,0,0);
        for (int i = 0; i < 3; i++) add(0,0,350,3,350,0, 2,0,1,3,0,0);
        add(0,0,350,3,350,0, 2,0,1,2,0,0);
        add(0,0,350,3,349,0, 2,0,1,2,0,0);
        add(0,0,350,3,348,0, 2,0,1,2,0,0);
        add(0,0,350,3,347,0, 2,1,1,2,0,0);
        add(0,0,350,3,349,0, 2,1,1,1,0,0);
        add(0,0,350,3,350,0, 2,0,1,1,0,0);
        for (int i = 0; i < 2; i++) add(0,0,350,3,350,0, 2,0,1,1,0,0);
        add(0,0,350,3,350,0, 3,0,1,0,1,0);
        add(0,0,350,3,350,0, 3,0,1,0,1,0);
        // acknowledge, held start blocked, invalid starts, cancel beats start
        add(1,0,350,3,350,0, 0,0,1,0,0,0);
        add(1,0,350,3,350,0, 0,0,1,0,0,0);
        add(0,0,350,3,350,0, 0,0,1,0,0,0);
        add(1,0,100,3, 70,0, 0,0,1,0,0,1);
        add(0,0,100,3, 70,0, 0,0,1,0,0,0);
        add(1,0,350,0, 70,0, 0,0,1,0,0,1);
        add(0,0,350,0, 70,0, 0,0,1,0,0,0);
        add(1,1,350,2, 70,0, 0,0,1,0,0,0);
        // over-temperature fault in COOK
        add(1,0,350,2, 70,0, 1,1,1,0,0,0);
        add(0,0,350,2,350,1, 2,0,1,2,0,0);
        add(0,0,350,2,371,0, 4,0,1,2,0,1);
        add(1,0,350,2,371,0, 4,0,1,2,0,1);
        add(0,1,350,2, 70,0, 0,0,1,0,0,0);
        // preheat timeout after LIM*T cycles
        add(1,0,350,3, 70,0, 1,1,1,0,0,0);
        for (int i = 0; i < 7; i++) add(0,0,350,3,70,0, 1,1,1,0,0,0);
        add(0,0,350,3, 70,0, 4,0,1,0,0,1);
        add(0,1,350,3, 70,0, 0,0,1,0,0,0);
        // exactly target+margin is not a fault; one-second cook
        add(1,0,350,1, 70,0, 1,1,1,0,0,0);
        add(0,0,350,1,370,1, 2,0,1,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,350,1,370,0, 2,0,1,1,0,0);
        add(0,0,350,1,370,0, 3,0,1,0,1,0);
        add(0,1,350,1,370,0, 0,0,1,0,0,0);
        // target range edges
        add(1,0,501,5, 70,0, 0,0,1,0,0,1);
        add(0,0,501,5, 70,0, 0,0,1,0,0,0);
        add(1,0,149,5, 70,0, 0,0,1,0,0,1);
        add(0,0,149,5, 70,0, 0,0,1,0,0,0);
        add(1,0,500,1,499,0, 1,1,1,0,0,0);
        add(0,1,500,1,499,0, 0,0,1,0,0,0);
        add(1,0,150,1,150,0, 1,0,1,0,0,0);
        add(0,1,150,1,150,0, 0,0,1,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].cancel, vecs[i].tgt, vecs[i].ct, vecs[i].temp, vecs[i].pre);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].heat, vecs[i].tid,
                vecs[i].tl, vecs[i].done, vecs[i].err);
        end

        // asynchronous reset in the middle of COOK
        drive(1,0,350,3, 70,0);
        drive(0,0,350,3,340,1);
        drive(0,0,350,3,340,0);
        chk("pre_rst_cook", 2, 1, 1, 3, 0, 0);
        #2 rst = 1'b1;
        #1 chk("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        drive(0,0,350,3,340,0);
        chk("post_rst_idle", 0, 0, 0, 0, 0, 0);

        model_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.cancel     = ($urandom_range(0, 49) == 0);
            bus.start      = ($urandom_range(0, 9) == 0);
            bus.targetIn   = 10'($urandom_range(140, 510));
            bus.cookTimeIn = 12'($urandom_range(0, 3));
            base = (m_state == 1 || m_state == 2) ? m_tgt : 300;
            bus.currentTemp = 10'(base - 8 + int'($urandom_range(0, 29)));
            bus.preheated  = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step();
            #1;
            chk("random", m_state, m_heat, m_tid, m_tl, m_done, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
